fetch_pc_unit: RTL and testbench

- Fetch-side consumer of the ID-stage branch target: owns the architectural PC and issues one instruction-memory request at a time.
- Accepts redirects from ID (PC+offset target), squashes wrong-path fetches, and presents fetched words to the IF/ID register with a valid/ready handshake.
- Sits between the branch-target adder/hazard logic in ID and the instruction memory port.

---
 rtl/fetch_pc_unit.sv | 114 +++++++++++
 tb/tb_fetch_pc_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: issues one instruction-memory request at a time, follows ID
// redirects, squashes wrong-path responses and hands words to IF/ID.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   output logic        redir_misaligned
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic        stale, stale_nxt;
   logic        armed;
   logic        accept;
   logic        capture;
   logic [31:0] pc;
   logic [31:0] fetch_pc;
   logic [31:0] redir_pc;

   // armed keeps the request low while in reset and goes high on the first
   // edge after release, so the request never depends on rst_n combinationally
   always_comb begin
      accept   = armed && (state == S_REQ) && imem_req_ready;
      capture  = (state == S_WAIT) && imem_rsp_valid && !stale && !redir_valid;
      redir_pc = {redir_target[31:2], 2'b00};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_REQ;
         stale <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         stale <= stale_nxt;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      stale_nxt = stale;
      case (state)
         S_REQ: begin
            if (accept) begin
               state_nxt = S_WAIT;
               stale_nxt = redir_valid;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_nxt = (stale || redir_valid) ? S_REQ : S_HOLD;
               stale_nxt = 1'b0;
            end else if (redir_valid) begin
               stale_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redir_valid || if_ready) begin
               state_nxt = S_REQ;
            end
         end
         default: begin
            state_nxt = S_REQ;
            stale_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      imem_req_valid = armed && (state == S_REQ);
      if_valid       = (state == S_HOLD);
      imem_req_addr  = pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc               <= RESET_PC;
         fetch_pc         <= '0;
         if_pc            <= '0;
         if_instr         <= '0;
         redir_misaligned <= 1'b0;
      end else begin
         redir_misaligned <= redir_valid && (redir_target[1:0] != 2'b00);
         if (accept) begin
            fetch_pc <= pc;
         end
         if (redir_valid) begin
            pc <= redir_pc;
         end else if (accept) begin
            pc <= pc + PC_STEP;
         end
         if (capture) begin
            if_pc    <= fetch_pc;
            if_instr <= imem_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects in each state,
// stall hold, misaligned target, PC wrap and mid-transaction reset.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        redir_misaligned;

   logic        b_rst_n;
   logic        b_req_valid;
   logic [31:0] b_req_addr;
   logic        b_rsp_valid;
   logic [31:0] b_rsp_data;
   logic        b_if_valid;
   logic [31:0] b_if_pc;
   logic [31:0] b_if_instr;
   logic        b_misaligned;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .redir_valid      (redir_valid),
      .redir_target     (redir_target),
      .imem_req_valid   (imem_req_valid),
      .imem_req_addr    (imem_req_addr),
      .imem_req_ready   (imem_req_ready),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .if_instr         (if_instr),
      .if_ready         (if_ready),
      .redir_misaligned (redir_misaligned)
   );

   fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
      .clk              (clk),
      .rst_n            (b_rst_n),
      .redir_valid      (1'b0),
      .redir_target     (32'h0),
      .imem_req_valid   (b_req_valid),
      .imem_req_addr    (b_req_addr),
      .imem_req_ready   (1'b1),
      .imem_rsp_valid   (b_rsp_valid),
      .imem_rsp_data    (b_rsp_data),
      .if_valid         (b_if_valid),
      .if_pc            (b_if_pc),
      .if_instr         (b_if_instr),
      .if_ready         (1'b1),
      .redir_misaligned (b_misaligned)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts and ends in REQ with the request presented; 1-cycle memory, if_ready high.
   task automatic fetch_one(input logic [31:0] addr);
      check("req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_addr", imem_req_addr, addr);
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      tick();
      check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("wait_if_valid", {31'b0, if_valid}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(addr);
      tick();
      imem_rsp_valid = 1'b0;
      check("hold_if_valid", {31'b0, if_valid}, 32'd1);
      check("hold_if_pc", if_pc, addr);
      check("hold_if_instr", if_instr, word_at(addr));
      tick();
      check("post_if_valid", {31'b0, if_valid}, 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      b_rst_n        = 1'b0;
      redir_valid    = 1'b0;
      redir_target   = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if_ready       = 1'b1;
      b_rsp_valid    = 1'b0;
      b_rsp_data     = '0;
      tick();
      tick();

      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_misaligned", {31'b0, redir_misaligned}, 32'd0);
      check("b_rst_addr", b_req_addr, 32'hFFFF_FFFC);
      check("b_rst_req_valid", {31'b0, b_req_valid}, 32'd0);

      // PC wrap on the second instance
      b_rst_n = 1'b1;
      tick();
      check("b_req_valid", {31'b0, b_req_valid}, 32'd1);
      check("b_req_addr0", b_req_addr, 32'hFFFF_FFFC);
      tick();
      b_rsp_valid = 1'b1;
      b_rsp_data  = 32'hCAFE_F00D;
      tick();
      b_rsp_valid = 1'b0;
      check("b_if_pc", b_if_pc, 32'hFFFF_FFFC);
      check("b_if_instr", b_if_instr, 32'hCAFE_F00D);
      tick();
      check("b_req_valid2", {31'b0, b_req_valid}, 32'd1);
      check("b_req_addr_wrap", b_req_addr, 32'h0000_0000);
      b_rst_n = 1'b0;

      // Release and sequential fetches
      rst_n = 1'b1;
      tick();
      fetch_one(32'h0);
      fetch_one(32'h4);

      // Redirect while waiting on 0x8: its response must be dropped
      check("req8_addr", imem_req_addr, 32'h8);
      tick();
      redir_valid  = 1'b1;
      redir_target = 32'h0000_0100;
      tick();
      redir_valid  = 1'b0;
      check("stale_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("aligned_no_pulse", {31'b0, redir_misaligned}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(32'h8);
      tick();
      imem_rsp_valid = 1'b0;
      check("drop8_if_valid", {31'b0, if_valid}, 32'd0);
      fetch_one(32'h100);

      // Redirect coincident with acceptance of 0x104
      check("req104_addr", imem_req_addr, 32'h104);
      redir_valid  = 1'b1;
      redir_target = 32'h0000_0200;
      tick();
      redir_valid  = 1'b0;
      check("wp_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(32'h104);
      tick();
      imem_rsp_valid = 1'b0;
      check("drop104_if_valid", {31'b0, if_valid}, 32'd0);
      fetch_one(32'h200);
      fetch_one(32'h204);

      // Redirect in REQ without acceptance, then a stalled HOLD
      imem_req_ready = 1'b0;
      redir_valid    = 1'b1;
      redir_target   = 32'h0000_0010;
      tick();
      redir_valid = 1'b0;
      check("req10_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req10_addr", imem_req_addr, 32'h10);
      imem_req_ready = 1'b1;
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(32'h10);
      if_ready       = 1'b0;
      tick();
      imem_rsp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_if_valid", {31'b0, if_valid}, 32'd1);
         check("stall_if_pc", if_pc, 32'h10);
         check("stall_if_instr", if_instr, word_at(32'h10));
         check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
         tick();
      end
      if_ready     = 1'b1;
      redir_valid  = 1'b1;
      redir_target = 32'h0000_0040;
      tick();
      redir_valid = 1'b0;
      check("hold_redir_if_valid", {31'b0, if_valid}, 32'd0);
      fetch_one(32'h40);

      // Misaligned redirect target
      imem_req_ready = 1'b0;
      redir_valid    = 1'b1;
      redir_target   = 32'h0000_0106;
      tick();
      redir_valid = 1'b0;
      check("mis_pulse", {31'b0, redir_misaligned}, 32'd1);
      check("mis_addr", imem_req_addr, 32'h104);
      tick();
      check("mis_pulse_end", {31'b0, redir_misaligned}, 32'd0);

      // Response ignored outside WAIT
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
      tick();
      imem_rsp_valid = 1'b0;
      check("proto_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("proto_if_valid", {31'b0, if_valid}, 32'd0);

      // Redirect and response together in WAIT; stale must end up clear
      imem_req_ready = 1'b1;
      tick();
      redir_valid    = 1'b1;
      redir_target   = 32'h0000_0300;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(32'h104);
      tick();
      redir_valid    = 1'b0;
      imem_rsp_valid = 1'b0;
      check("rr_if_valid", {31'b0, if_valid}, 32'd0);
      fetch_one(32'h300);

      // Reset mid-WAIT is asynchronous; a late response after release is ignored
      tick();
      check("mid_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("arst_addr", imem_req_addr, 32'h0);
      check("arst_if_pc", if_pc, 32'h0);
      check("arst_if_instr", if_instr, 32'h0);
      tick();
      rst_n          = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      check("late_if_valid", {31'b0, if_valid}, 32'd0);
      check("late_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("late_req_addr", imem_req_addr, 32'h0);
      tick();
      check("late_if_valid2", {31'b0, if_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
